// File: rtl/load_store_pipe_pkg.sv
// load_store_pkg: shared definitions for the load/store pipe.
//   - access-size (order) encodings
//   - FSM state encoding
//   - alignment-fault completion flag
//   - helpers for the effective byte lane and misalignment detection
// Used by: load_store_pipe, load_store_data_align.
package load_store_pkg;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_NONE = 2'b11;

    localparam logic [11:0] FLAG_ALIGN_FAULT = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } ldst_state_t;

    // Low address bits that cannot be honoured for the access size are forced
    // to zero, so a misaligned half/word access lands on its natural boundary.
    function automatic logic [1:0] eff_lane(input logic [1:0] order, input logic [1:0] addr_lo);
        logic [1:0] lane;
        case (order)
            ORDER_HALF: lane = {addr_lo[1], 1'b0};
            ORDER_WORD: lane = 2'b00;
            default:    lane = addr_lo;
        endcase
        return lane;
    endfunction

    // True when the address is not naturally aligned for the access size.
    function automatic logic is_misaligned(input logic [1:0] order, input logic [1:0] addr_lo);
        logic bad;
        case (order)
            ORDER_HALF: bad = addr_lo[0];
            ORDER_WORD: bad = |addr_lo;
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_pipe_if.sv
// load_store_pipe_if: request side (iLDST_*/oLDST_*) and memory side
// (oMEM_*/iMEM_*) of the load/store pipe bundled in one interface.
//   slave  : view taken by load_store_pipe
//   master : view taken by the surrounding logic (core + memory)
interface load_store_pipe_if;
    logic        iLDST_REQ;
    logic        oLDST_BUSY;
    logic [1:0]  iLDST_ORDER;
    logic [3:0]  iLDST_MASK;
    logic        iLDST_RW;
    logic [13:0] iLDST_ASID;
    logic [1:0]  iLDST_MMUMOD;
    logic [2:0]  iLDST_MMUPS;
    logic [31:0] iLDST_PDT;
    logic [31:0] iLDST_ADDR;
    logic [31:0] iLDST_DATA;
    logic        oLDST_VALID;
    logic [11:0] oLDST_MMU_FLAGS;
    logic [31:0] oLDST_DATA;

    logic        oMEM_REQ;
    logic        iMEM_BUSY;
    logic        oMEM_RW;
    logic [3:0]  oMEM_BYTEENA;
    logic [31:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic [13:0] oMEM_ASID;
    logic [1:0]  oMEM_MMUMOD;
    logic [2:0]  oMEM_MMUPS;
    logic [31:0] oMEM_PDT;
    logic        iMEM_VALID;
    logic [11:0] iMEM_MMU_FLAGS;
    logic [31:0] iMEM_DATA;

    modport slave (
        input  iLDST_REQ, iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ASID, iLDST_MMUMOD,
               iLDST_MMUPS, iLDST_PDT, iLDST_ADDR, iLDST_DATA,
               iMEM_BUSY, iMEM_VALID, iMEM_MMU_FLAGS, iMEM_DATA,
        output oLDST_BUSY, oLDST_VALID, oLDST_MMU_FLAGS, oLDST_DATA,
               oMEM_REQ, oMEM_RW, oMEM_BYTEENA, oMEM_ADDR, oMEM_DATA,
               oMEM_ASID, oMEM_MMUMOD, oMEM_MMUPS, oMEM_PDT
    );

    modport master (
        output iLDST_REQ, iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ASID, iLDST_MMUMOD,
               iLDST_MMUPS, iLDST_PDT, iLDST_ADDR, iLDST_DATA,
               iMEM_BUSY, iMEM_VALID, iMEM_MMU_FLAGS, iMEM_DATA,
        input  oLDST_BUSY, oLDST_VALID, oLDST_MMU_FLAGS, oLDST_DATA,
               oMEM_REQ, oMEM_RW, oMEM_BYTEENA, oMEM_ADDR, oMEM_DATA,
               oMEM_ASID, oMEM_MMUMOD, oMEM_MMUPS, oMEM_PDT
    );
endinterface

// File: rtl/load_store_pipe_data_align.sv
// load_store_data_align: combinational lane logic for the load/store pipe.
//   i_order/i_lane/i_mask/i_st_data -> o_byteena, o_st_data (request side)
//   i_ld_order/i_ld_lane/i_mem_data -> o_ld_data           (response side)
// o_byteena = size-based lane pattern & mask; o_st_data = store data moved
// to its byte lane; o_ld_data = selected bytes right-justified, zero-extended.
module load_store_data_align
    import load_store_pkg::*;
(
    input  logic [1:0]  i_order,
    input  logic [1:0]  i_lane,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_byteena,
    output logic [31:0] o_st_data,
    input  logic [1:0]  i_ld_order,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_ld_data
);

    logic [3:0]  w_be_base;
    logic [31:0] w_ld_shift;

    // Byte-enable pattern for the access size, shifted to the lane.
    always_comb begin
        case (i_order)
            ORDER_BYTE: w_be_base = 4'b0001 << i_lane;
            ORDER_HALF: w_be_base = 4'b0011 << i_lane;
            ORDER_WORD: w_be_base = 4'b1111;
            default:    w_be_base = 4'b0000;
        endcase
    end

    assign o_byteena  = w_be_base & i_mask;
    assign o_st_data  = i_st_data << {i_ld_lane_unused_guard(i_lane), 3'b000};
    assign w_ld_shift = i_mem_data >> {i_ld_lane, 3'b000};

    // Keep only the bytes of the access size; upper bits read as zero.
    always_comb begin
        case (i_ld_order)
            ORDER_BYTE: o_ld_data = {24'h000000, w_ld_shift[7:0]};
            ORDER_HALF: o_ld_data = {16'h0000, w_ld_shift[15:0]};
            ORDER_WORD: o_ld_data = w_ld_shift;
            default:    o_ld_data = 32'h00000000;
        endcase
    end

    // Identity on the lane; keeps the shift amount expression 5 bits wide.
    function automatic logic [1:0] i_ld_lane_unused_guard(input logic [1:0] lane);
        return lane;
    endfunction

endmodule

// File: rtl/load_store_pipe.sv
// load_store_pipe: single-outstanding load/store unit between a core and a
// word-wide memory. FSM IDLE -> REQ -> WAIT -> RESP (or IDLE -> RESP for
// order 11 / alignment faults).
// Ports:
//   iCLOCK  rising-edge clock
//   iRESET  asynchronous active-high reset (all outputs 0, FSM to IDLE)
//   bus     load_store_pipe_if.slave: iLDST_*/oLDST_* request side and
//           oMEM_*/iMEM_* memory side; all outputs are registered.
// Configuration:
//   LDST_ALIGN_CHECK_EN  defined: misaligned half/word accesses complete
//                        without memory access, flags 12'h800, data 0.
//                        undefined: offending low address bits are ignored.
module load_store_pipe
    import load_store_pkg::*;
(
    input  logic iCLOCK,
    input  logic iRESET,
    load_store_pipe_if.slave bus
);

    ldst_state_t r_state;
    logic        r_busy;
    logic        r_valid;
    logic [31:0] r_ldst_data;
    logic [11:0] r_ldst_flags;
    logic        r_mem_req;
    logic        r_mem_rw;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic [13:0] r_mem_asid;
    logic [1:0]  r_mem_mmumod;
    logic [2:0]  r_mem_mmups;
    logic [31:0] r_mem_pdt;
    logic [1:0]  r_order;
    logic [1:0]  r_lane;

    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;

    assign w_lane = eff_lane(bus.iLDST_ORDER, bus.iLDST_ADDR[1:0]);

`ifdef LDST_ALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = is_misaligned(bus.iLDST_ORDER, bus.iLDST_ADDR[1:0]);
`endif

    // Request-side lanes come straight from the inputs (captured on accept);
    // response-side extraction uses the latched order and lane.
    load_store_data_align u_align (
        .i_order    (bus.iLDST_ORDER),
        .i_lane     (w_lane),
        .i_mask     (bus.iLDST_MASK),
        .i_st_data  (bus.iLDST_DATA),
        .o_byteena  (w_be),
        .o_st_data  (w_st_data),
        .i_ld_order (r_order),
        .i_ld_lane  (r_lane),
        .i_mem_data (bus.iMEM_DATA),
        .o_ld_data  (w_ld_data)
    );

    // Transaction FSM with registered handshake, memory and completion outputs.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_ldst_data  <= 32'h00000000;
            r_ldst_flags <= 12'h000;
            r_mem_req    <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_be     <= 4'h0;
            r_mem_addr   <= 32'h00000000;
            r_mem_data   <= 32'h00000000;
            r_mem_asid   <= 14'h0000;
            r_mem_mmumod <= 2'b00;
            r_mem_mmups  <= 3'b000;
            r_mem_pdt    <= 32'h00000000;
            r_order      <= 2'b00;
            r_lane       <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Busy is low in IDLE, so a raised request is accepted.
                    if (bus.iLDST_REQ) begin
                        r_busy       <= 1'b1;
                        r_order      <= bus.iLDST_ORDER;
                        r_lane       <= w_lane;
                        r_mem_rw     <= bus.iLDST_RW;
                        r_mem_be     <= w_be;
                        r_mem_addr   <= {bus.iLDST_ADDR[31:2], 2'b00};
                        r_mem_data   <= w_st_data;
                        r_mem_asid   <= bus.iLDST_ASID;
                        r_mem_mmumod <= bus.iLDST_MMUMOD;
                        r_mem_mmups  <= bus.iLDST_MMUPS;
                        r_mem_pdt    <= bus.iLDST_PDT;
                        if (bus.iLDST_ORDER == ORDER_NONE) begin
                            r_ldst_data  <= 32'h00000000;
                            r_ldst_flags <= 12'h000;
                            r_valid      <= 1'b1;
                            r_state      <= ST_RESP;
                        end
`ifdef LDST_ALIGN_CHECK_EN
                        else if (w_misalign) begin
                            r_ldst_data  <= 32'h00000000;
                            r_ldst_flags <= FLAG_ALIGN_FAULT;
                            r_valid      <= 1'b1;
                            r_state      <= ST_RESP;
                        end
`endif
                        else begin
                            r_mem_req <= 1'b1;
                            r_state   <= ST_REQ;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (!bus.iMEM_BUSY) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_WAIT;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    // Writes also wait for the memory acknowledge; their data reads as 0.
                    if (bus.iMEM_VALID) begin
                        r_ldst_data  <= r_mem_rw ? 32'h00000000 : w_ld_data;
                        r_ldst_flags <= bus.iMEM_MMU_FLAGS;
                        r_valid      <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oLDST_BUSY      = r_busy;
    assign bus.oLDST_VALID     = r_valid;
    assign bus.oLDST_DATA      = r_ldst_data;
    assign bus.oLDST_MMU_FLAGS = r_ldst_flags;
    assign bus.oMEM_REQ        = r_mem_req;
    assign bus.oMEM_RW         = r_mem_rw;
    assign bus.oMEM_BYTEENA    = r_mem_be;
    assign bus.oMEM_ADDR       = r_mem_addr;
    assign bus.oMEM_DATA       = r_mem_data;
    assign bus.oMEM_ASID       = r_mem_asid;
    assign bus.oMEM_MMUMOD     = r_mem_mmumod;
    assign bus.oMEM_MMUPS      = r_mem_mmups;
    assign bus.oMEM_PDT        = r_mem_pdt;

endmodule

// File: tb/tb_load_store_pipe.sv
// Testbench for load_store_pipe: scoreboard of expected completions
// (data, flags, cycle) pushed when a request is driven and popped by a
// monitor when oLDST_VALID is seen. Memory side is driven by the bench.
module tb_load_store_pipe;

    logic iCLOCK = 1'b0;
    logic iRESET = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    typedef struct {
        logic [31:0] data;
        logic [11:0] flags;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    load_store_pipe_if bus();

    load_store_pipe dut (
        .iCLOCK (iCLOCK),
        .iRESET (iRESET),
        .bus    (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    always @(posedge iCLOCK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Completion monitor: every oLDST_VALID cycle must match the oldest expectation.
    always @(negedge iCLOCK) begin
        if (!iRESET && bus.oLDST_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                check_value("unexpected_valid", 32'(bus.oLDST_VALID), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_value("ld_data",  bus.oLDST_DATA, e.data);
                check_value("ld_flags", 32'(bus.oLDST_MMU_FLAGS), 32'(e.flags));
                check_value("ld_cycle", 32'(cyc), 32'(e.at_cyc));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge iCLOCK);
            #1;
        end
        check_value("sb_drain", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, ".busy"},  32'(bus.oLDST_BUSY), 32'h0);
        check_value({tag, ".valid"}, 32'(bus.oLDST_VALID), 32'h0);
        check_value({tag, ".mreq"},  32'(bus.oMEM_REQ), 32'h0);
        check_value({tag, ".maddr"}, bus.oMEM_ADDR, 32'h0);
        check_value({tag, ".mdata"}, bus.oMEM_DATA, 32'h0);
        check_value({tag, ".mbe"},   32'(bus.oMEM_BYTEENA), 32'h0);
        check_value({tag, ".ldata"}, bus.oLDST_DATA, 32'h0);
        check_value({tag, ".flags"}, 32'(bus.oLDST_MMU_FLAGS), 32'h0);
        check_value({tag, ".pdt"},   bus.oMEM_PDT, 32'h0);
    endtask

    // One full transaction; starts and ends at a falling edge.
    task automatic run_txn(input string tag, input logic [1:0] order, input logic rw,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask,
                           input logic [31:0] mrdata, input logic [11:0] mflags, input int stall,
                           input logic use_mem, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_mdata, input logic [31:0] exp_ld, input logic [11:0] exp_flags);
        int a;
        exp_t e;
        logic [13:0] asid;
        logic [31:0] pdt;
        asid = addr[13:0] ^ 14'h2A5A;
        pdt  = ~addr;
        check_value({tag, ".idle_busy"}, 32'(bus.oLDST_BUSY), 32'h0);
        bus.iLDST_REQ    = 1'b1;
        bus.iLDST_ORDER  = order;
        bus.iLDST_RW     = rw;
        bus.iLDST_ADDR   = addr;
        bus.iLDST_DATA   = wdata;
        bus.iLDST_MASK   = mask;
        bus.iLDST_ASID   = asid;
        bus.iLDST_MMUMOD = addr[3:2];
        bus.iLDST_MMUPS  = 3'd5;
        bus.iLDST_PDT    = pdt;
        a = cyc + 1;
        e.data   = exp_ld;
        e.flags  = exp_flags;
        e.at_cyc = use_mem ? (a + 2 + stall) : a;
        sb.push_back(e);
        @(negedge iCLOCK);
        bus.iLDST_REQ = 1'b0;
        if (use_mem) begin
            for (int s = 0; s <= stall; s++) begin
                check_value({tag, ".mreq"},  32'(bus.oMEM_REQ), 32'h1);
                check_value({tag, ".busy"},  32'(bus.oLDST_BUSY), 32'h1);
                check_value({tag, ".mrw"},   32'(bus.oMEM_RW), 32'(rw));
                check_value({tag, ".maddr"}, bus.oMEM_ADDR, exp_addr);
                check_value({tag, ".mbe"},   32'(bus.oMEM_BYTEENA), 32'(exp_be));
                check_value({tag, ".mdata"}, bus.oMEM_DATA, exp_mdata);
                check_value({tag, ".asid"},  32'(bus.oMEM_ASID), 32'(asid));
                check_value({tag, ".pdt"},   bus.oMEM_PDT, pdt);
                bus.iMEM_BUSY = (s < stall);
                @(negedge iCLOCK);
            end
            check_value({tag, ".wait_mreq"}, 32'(bus.oMEM_REQ), 32'h0);
            check_value({tag, ".wait_busy"}, 32'(bus.oLDST_BUSY), 32'h1);
            bus.iMEM_VALID     = 1'b1;
            bus.iMEM_DATA      = mrdata;
            bus.iMEM_MMU_FLAGS = mflags;
            @(negedge iCLOCK);
            bus.iMEM_VALID = 1'b0;
        end else begin
            check_value({tag, ".no_mreq"}, 32'(bus.oMEM_REQ), 32'h0);
        end
        #1;
        wait_drain();
        @(negedge iCLOCK);
    endtask

    initial begin
        int a;
        exp_t e;
        bus.iLDST_REQ = 1'b0;      bus.iLDST_ORDER = 2'b00;   bus.iLDST_MASK = 4'h0;
        bus.iLDST_RW = 1'b0;       bus.iLDST_ASID = 14'h0;    bus.iLDST_MMUMOD = 2'b00;
        bus.iLDST_MMUPS = 3'b000;  bus.iLDST_PDT = 32'h0;     bus.iLDST_ADDR = 32'h0;
        bus.iLDST_DATA = 32'h0;    bus.iMEM_BUSY = 1'b0;      bus.iMEM_VALID = 1'b0;
        bus.iMEM_MMU_FLAGS = 12'h0; bus.iMEM_DATA = 32'h0;

        // Reset: request and memory-valid during reset are ignored, outputs 0.
        repeat (2) @(negedge iCLOCK);
        bus.iLDST_REQ  = 1'b1;
        bus.iMEM_VALID = 1'b1;
        @(negedge iCLOCK);
        check_all_zero("reset");
        bus.iLDST_REQ  = 1'b0;
        iRESET = 1'b0;
        @(negedge iCLOCK);
        bus.iMEM_VALID = 1'b0;
        @(negedge iCLOCK);
        check_value("idle_memvalid_busy", 32'(bus.oLDST_BUSY), 32'h0);

        // Byte write, lane 3.
        run_txn("bwr", 2'b00, 1'b1, 32'h103, 32'hAB, 4'hF, 32'hFFFFFFFF, 12'h055, 0,
                1'b1, 32'h100, 4'b1000, 32'hAB000000, 32'h0, 12'h055);
        // Half read, lane 2.
        run_txn("hrd", 2'b01, 1'b0, 32'h202, 32'h0, 4'hF, 32'h12345678, 12'h0A5, 0,
                1'b1, 32'h200, 4'b1100, 32'h0, 32'h00001234, 12'h0A5);
        repeat (3) @(negedge iCLOCK);
        check_value("hold_data",  bus.oLDST_DATA, 32'h00001234);
        check_value("hold_flags", 32'(bus.oLDST_MMU_FLAGS), 32'h0A5);
        // Word read with 4 stall cycles.
        run_txn("wstall", 2'b10, 1'b0, 32'h300, 32'h0, 4'hF, 32'hDEADBEEF, 12'h3C0, 4,
                1'b1, 32'h300, 4'b1111, 32'h0, 32'hDEADBEEF, 12'h3C0);
        // Half write, lane 2, mask clears upper lane.
        run_txn("hwr_mask", 2'b01, 1'b1, 32'h1006, 32'h0000BEEF, 4'h7, 32'h0, 12'h001, 1,
                1'b1, 32'h1004, 4'b0100, 32'hBEEF0000, 32'h0, 12'h001);
        // Byte read, lane 2.
        run_txn("brd", 2'b00, 1'b0, 32'h2002, 32'h0, 4'hF, 32'h11223344, 12'h000, 0,
                1'b1, 32'h2000, 4'b0100, 32'h0, 32'h00000022, 12'h000);
`ifdef LDST_ALIGN_CHECK_EN
        run_txn("wmis", 2'b10, 1'b0, 32'h001, 32'h0, 4'hF, 32'h0, 12'h000, 0,
                1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 12'h800);
        run_txn("hmis", 2'b01, 1'b0, 32'h503, 32'h0, 4'hF, 32'h0, 12'h000, 0,
                1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 12'h800);
`else
        run_txn("wmis", 2'b10, 1'b0, 32'h001, 32'h0, 4'hF, 32'h89ABCDEF, 12'h010, 0,
                1'b1, 32'h000, 4'b1111, 32'h0, 32'h89ABCDEF, 12'h010);
        run_txn("hmis", 2'b01, 1'b0, 32'h503, 32'h0, 4'hF, 32'hA1B2C3D4, 12'h020, 0,
                1'b1, 32'h500, 4'b1100, 32'h0, 32'h0000A1B2, 12'h020);
`endif

        // Order 11 with request held high: second accepted right after RESP.
        bus.iLDST_REQ   = 1'b1;
        bus.iLDST_ORDER = 2'b11;
        bus.iLDST_DATA  = 32'hFFFFFFFF;
        bus.iLDST_ADDR  = 32'h44;
        a = cyc + 1;
        e.data = 32'h0; e.flags = 12'h000;
        e.at_cyc = a;     sb.push_back(e);
        e.at_cyc = a + 2; sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLOCK);
            if (cyc == a) check_value("none.busy", 32'(bus.oLDST_BUSY), 32'h1);
            if (cyc >= a + 2) break;
        end
        bus.iLDST_REQ = 1'b0;
        #1;
        wait_drain();
        @(negedge iCLOCK);

        // Reset while waiting for memory; a late iMEM_VALID must be ignored.
        bus.iLDST_REQ = 1'b1; bus.iLDST_ORDER = 2'b10; bus.iLDST_RW = 1'b0;
        bus.iLDST_ADDR = 32'h400; bus.iLDST_MASK = 4'hF; bus.iMEM_BUSY = 1'b0;
        @(negedge iCLOCK);
        bus.iLDST_REQ = 1'b0;
        @(negedge iCLOCK);
        check_value("rst_wait.busy", 32'(bus.oLDST_BUSY), 32'h1);
        iRESET = 1'b1;
        #1;
        check_all_zero("rst_wait");
        @(negedge iCLOCK);
        iRESET = 1'b0;
        @(negedge iCLOCK);
        bus.iMEM_VALID = 1'b1; bus.iMEM_DATA = 32'h5A5A5A5A; bus.iMEM_MMU_FLAGS = 12'hFFF;
        @(negedge iCLOCK);
        bus.iMEM_VALID = 1'b0;
        repeat (3) @(negedge iCLOCK);
        check_value("rst_wait.after_busy", 32'(bus.oLDST_BUSY), 32'h0);
        check_value("rst_wait.after_data", bus.oLDST_DATA, 32'h0);
        run_txn("post_rst", 2'b00, 1'b1, 32'h7F1, 32'h123456C3, 4'hF, 32'h0, 12'h002, 0,
                1'b1, 32'h7F0, 4'b0010, 32'h3456C300, 32'h0, 12'h002);

        check_value("sb_final", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
